// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//
// Shared definitions for the pipelined add/subtract unit:
//   - OP_ADD / OP_SUB : encoding of the in_sub control input
//   - chunk_width()   : per-stage chunk width CW = WIDTH / STAGES
//   - cfg_ok()        : legality of a WIDTH/STAGES pair. The top module calls
//                       it at elaboration and stops with $error if it fails.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // STAGES must lie in 1..WIDTH and divide WIDTH exactly, so that every
    // stage handles a chunk of the same width.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
//
// Purely combinational CW-bit adder slice. The top module uses one slice per
// pipeline stage.
//
// Ports:
//   a, b          in  CW  chunk operands (for subtraction, b arrives already inverted)
//   cin           in  1   carry into bit 0 of the chunk
//   sum           out CW  chunk result
//   cout          out 1   carry out of the chunk MSB
//   msb_carry_in  out 1   carry into the chunk MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          msb_carry_in
);

    // The sum is one bit wider than a chunk; the extra top bit is the carry out.
    logic [CW:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    assign sum  = full[CW-1:0];
    assign cout = full[CW];

    // The sum bit at the MSB is a ^ b ^ carry_in, so the carry into the MSB
    // can be recovered from it. This holds for every CW, including CW = 1.
    assign msb_carry_in = sum[CW-1] ^ a[CW-1] ^ b[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// WIDTH-bit add/subtract unit with a valid/ready handshake. The unit is split
// into STAGES carry-registered chunks of CW = WIDTH/STAGES bits. Stage k adds
// chunk k and registers the partial result together with the carry. It accepts
// one operation per cycle, and backpressure stalls the pipeline without losing
// data. Empty stages (bubbles) are refilled so that no gap is kept in the pipe.
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous, active-high reset
//   in_valid   in  1      operands present
//   in_ready   out 1      block can accept this cycle
//   in_a       in  WIDTH  operand A
//   in_b       in  WIDTH  operand B
//   in_cin     in  1      carry-in (add) / borrow-in (sub)
//   in_sub     in  1      OP_ADD: A+B+cin, OP_SUB: A-B-cin
//   out_valid  out 1      result present
//   out_ready  in  1      consumer accepts this cycle
//   out_sum    out WIDTH  result modulo 2^WIDTH
//   out_cout   out 1      raw carry out of the MSB (sub: 1 = no borrow)
//   out_ovf    out 1      signed overflow. It is 0 unless PIPELINED_ADDER_OVF_EN is defined.
//
// Build option:
//   PIPELINED_ADDER_OVF_EN - when defined, out_ovf is registered as
//   carry-into-MSB XOR carry-out-of-MSB of the final chunk. When undefined,
//   out_ovf is tied to 0 and the overflow logic is left out.
//
// The outputs come straight from the last stage register, so there is no
// combinational path from in_* to out_*. There is, however, a combinational
// path from out_ready through the per-stage advance chain to in_ready.
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
    end

    // Contents of one stage register. The low chunks of acc already hold
    // result bits; its high chunks still hold operand A. Field b holds
    // operand B, already inverted for subtraction.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] b;
        logic             carry;
    } stage_t;

    stage_t stage_q [STAGES];   // stage registers
    stage_t src     [STAGES];   // what feeds each stage's chunk adder
    stage_t nxt     [STAGES];   // value each stage loads when it advances

    logic [STAGES-1:0]         adv;
    logic [STAGES-1:0][CW-1:0] chunk_sum;
    logic [STAGES-1:0]         chunk_cout;
    logic [STAGES-1:0]         msb_cin;

    // A stage advances if it is empty or if the stage after it moves on. The
    // last stage moves on when out_ready is high, so out_ready feeds
    // combinationally into in_ready through this chain.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        adv = '0;
        adv[STAGES-1] = !stage_q[STAGES-1].valid || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !stage_q[k].valid || adv[k+1];
        end
    end

    assign in_ready = adv[0];

    // Stage 0 is fed from the input port. For subtraction, A - B - cin is
    // computed as A + ~B + ~cin. Every other stage is fed from the register
    // of the stage before it.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            src[k] = '0;
        end
        src[0].valid = in_valid;
        src[0].acc   = in_a;
        src[0].b     = (in_sub == OP_SUB) ? ~in_b   : in_b;
        src[0].carry = (in_sub == OP_SUB) ? ~in_cin : in_cin;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        adder_chunk #(
            .CW(CW)
        ) u_chunk (
            .a           (src[k].acc[k*CW +: CW]),
            .b           (src[k].b[k*CW +: CW]),
            .cin         (src[k].carry),
            .sum         (chunk_sum[k]),
            .cout        (chunk_cout[k]),
            .msb_carry_in(msb_cin[k])
        );
    end

    // Each stage overwrites its own chunk of acc with the result bits and
    // passes its carry on to the next stage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]                   = src[k];
            nxt[k].acc[k*CW +: CW]   = chunk_sum[k];
            nxt[k].carry             = chunk_cout[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the whole payload is reset, not only the valid bits, because
        // out_sum/out_cout come straight from the last stage and must read 0
        // after reset.
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                // NOTE: state is updated with non-blocking assignments, so every
                // stage reads its neighbour's value from before the edge.
                if (adv[k]) begin
                    stage_q[k] <= nxt[k];
                end
            end
        end
    end

    assign out_valid = stage_q[STAGES-1].valid;
    assign out_sum   = stage_q[STAGES-1].acc;
    assign out_cout  = stage_q[STAGES-1].carry;

`ifdef PIPELINED_ADDER_OVF_EN
    // The overflow flag is computed in the last stage and held alongside the
    // result in that stage's register.
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv[STAGES-1]) begin
            ovf_q <= chunk_cout[STAGES-1] ^ msb_cin[STAGES-1];
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    // These bits have no reader in some builds: the inverted B of the last
    // stage, and the carry into the MSB of chunks other than the last one.
    logic unused_sink;
    assign unused_sink = ^{msb_cin, stage_q[STAGES-1].b};

endmodule
